// File: rtl/tcdm_bank_arbiter.sv
// Per-bank N:1 round-robin arbiter for the TCDM crossbar. Granted master IDs are
// queued in order so each bank response is routed back to the master that issued it.
module tcdm_bank_arbiter #(
  parameter  int NUM_MASTER      = 4,
  parameter  int DATA_WIDTH      = 32,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int BE_WIDTH        = DATA_WIDTH / 8,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int IDW             = $clog2(NUM_MASTER),
  localparam int CNTW            = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  resetn_i,
  // master side
  input  logic [NUM_MASTER-1:0]                 mas_req_i,
  output logic [NUM_MASTER-1:0]                 mas_gnt_o,
  input  logic [NUM_MASTER-1:0][ADDR_WIDTH-1:0] mas_addr_i,
  input  logic [NUM_MASTER-1:0]                 mas_wen_i,
  input  logic [NUM_MASTER-1:0][BE_WIDTH-1:0]   mas_be_i,
  input  logic [NUM_MASTER-1:0][DATA_WIDTH-1:0] mas_data_i,
  output logic [NUM_MASTER-1:0][DATA_WIDTH-1:0] mas_r_data_o,
  output logic [NUM_MASTER-1:0]                 mas_r_valid_o,
  input  logic [NUM_MASTER-1:0]                 mas_r_ready_i,
  // bank side
  output logic                                  slv_req_o,
  input  logic                                  slv_gnt_i,
  output logic [ADDR_WIDTH-1:0]                 slv_addr_o,
  output logic                                  slv_wen_o,
  output logic [BE_WIDTH-1:0]                   slv_be_o,
  output logic [DATA_WIDTH-1:0]                 slv_data_o,
  input  logic [DATA_WIDTH-1:0]                 slv_r_data_i,
  input  logic                                  slv_r_valid_i,
  output logic                                  slv_r_ready_o,
  // status
  output logic [CNTW-1:0]                       outstanding_o,
  output logic                                  resp_err_o
);

  localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDW-1:0]  r_rr;
  logic [IDW-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW-1:0] r_wr_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_resp_err;

  logic [IDW-1:0]  w_winner;
  logic            w_found;
  logic [IDW-1:0]  w_head;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNTW'(MAX_OUTSTANDING));
  assign w_head  = r_fifo[r_rd_ptr];

  // Scan starting at the round-robin pointer, wrapping once around all masters.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_winner = '0;
    w_found  = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_MASTER; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
      if (!w_found && mas_req_i[idx]) begin
        w_winner = IDW'(idx);
        w_found  = 1'b1;
      end
    end
  end

  // Request channel: no bypass, a full FIFO blocks even when it pops this cycle.
  assign slv_req_o  = (|mas_req_i) & ~w_full;
  assign slv_addr_o = mas_addr_i[w_winner];
  assign slv_wen_o  = mas_wen_i[w_winner];
  assign slv_be_o   = mas_be_i[w_winner];
  assign slv_data_o = mas_data_i[w_winner];
  assign w_push     = slv_req_o & slv_gnt_i;

  always_comb begin
    mas_gnt_o           = '0;
    mas_gnt_o[w_winner] = w_push;
  end

  // Response channel: routed to the oldest outstanding ID.
  assign slv_r_ready_o = ~w_empty & mas_r_ready_i[w_head];
  assign w_pop         = slv_r_valid_i & slv_r_ready_o;
  assign mas_r_data_o  = {NUM_MASTER{slv_r_data_i}};

  always_comb begin
    mas_r_valid_o         = '0;
    mas_r_valid_o[w_head] = slv_r_valid_i & ~w_empty;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rr       <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_rr     <= (w_winner == IDW'(NUM_MASTER - 1)) ? '0 : w_winner + IDW'(1);
        r_wr_ptr <= (r_wr_ptr == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + PTRW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + PTRW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (slv_r_valid_i && w_empty) r_resp_err <= 1'b1;
    end
  end

  // NOTE: the ID storage has no reset; entries are only read once the count says
  // they were written, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_winner;
  end

  assign outstanding_o = r_count;
  assign resp_err_o    = r_resp_err;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter: inputs change on the falling edge,
// outputs are compared 1 ns later, state advances on the next rising edge.
module tb_tcdm_bank_arbiter;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);

  logic                  clk_i = 1'b0;
  logic                  resetn_i;
  logic [NM-1:0]         mas_req_i;
  logic [NM-1:0]         mas_gnt_o;
  logic [NM-1:0][AW-1:0] mas_addr_i;
  logic [NM-1:0]         mas_wen_i;
  logic [NM-1:0][BW-1:0] mas_be_i;
  logic [NM-1:0][DW-1:0] mas_data_i;
  logic [NM-1:0][DW-1:0] mas_r_data_o;
  logic [NM-1:0]         mas_r_valid_o;
  logic [NM-1:0]         mas_r_ready_i;
  logic                  slv_req_o;
  logic                  slv_gnt_i;
  logic [AW-1:0]         slv_addr_o;
  logic                  slv_wen_o;
  logic [BW-1:0]         slv_be_o;
  logic [DW-1:0]         slv_data_o;
  logic [DW-1:0]         slv_r_data_i;
  logic                  slv_r_valid_i;
  logic                  slv_r_ready_o;
  logic [CW-1:0]         outstanding_o;
  logic                  resp_err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  tcdm_bank_arbiter #(
    .NUM_MASTER(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .mas_req_i(mas_req_i), .mas_gnt_o(mas_gnt_o), .mas_addr_i(mas_addr_i),
    .mas_wen_i(mas_wen_i), .mas_be_i(mas_be_i), .mas_data_i(mas_data_i),
    .mas_r_data_o(mas_r_data_o), .mas_r_valid_o(mas_r_valid_o), .mas_r_ready_i(mas_r_ready_i),
    .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_addr_o(slv_addr_o),
    .slv_wen_o(slv_wen_o), .slv_be_o(slv_be_o), .slv_data_o(slv_data_o),
    .slv_r_data_i(slv_r_data_i), .slv_r_valid_i(slv_r_valid_i), .slv_r_ready_o(slv_r_ready_o),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge and apply one cycle of stimulus.
  task automatic drive(input logic [NM-1:0] req, input logic gnt,
                       input logic rvalid, input logic [DW-1:0] rdata,
                       input logic [NM-1:0] rready);
    @(negedge clk_i);
    mas_req_i     = req;
    slv_gnt_i     = gnt;
    slv_r_valid_i = rvalid;
    slv_r_data_i  = rdata;
    mas_r_ready_i = rready;
    #1;
  endtask

  // Round-robin sequences: expected grant and routed response per cycle.
  logic [NM-1:0] rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NM-1:0] rr_rval [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NM-1:0] sk_gnt  [3] = '{4'b1000, 4'b0010, 4'b1000};
  logic [NM-1:0] sk_rval [3] = '{4'b0010, 4'b1000, 4'b0010};
  logic [NM-1:0] fl_gnt  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    for (int i = 0; i < NM; i++) begin
      mas_addr_i[i] = AW'(32'h1000 + 4 * i);
      mas_data_i[i] = DW'(32'hD000 + i);
      mas_be_i[i]   = BW'(i + 1);
    end
    mas_wen_i     = 4'b0101;
    resetn_i      = 1'b0;
    mas_req_i     = '0;
    slv_gnt_i     = 1'b0;
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = '0;
    mas_r_ready_i = '1;

    // Reset state, even with a response presented.
    #12;
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_r_ready",     64'(slv_r_ready_o), 64'd0);
    check("rst_r_valid",     64'(mas_r_valid_o), 64'd0);
    check("rst_err",         64'(resp_err_o),    64'd0);
    slv_r_valid_i = 1'b0;
    @(negedge clk_i);
    resetn_i = 1'b1;

    // Idle: no request, master 0 on the bank lines.
    drive(4'b0000, 1'b1, 1'b0, '0, 4'b1111);
    check("idle_req",  64'(slv_req_o),  64'd0);
    check("idle_gnt",  64'(mas_gnt_o),  64'd0);
    check("idle_addr", 64'(slv_addr_o), 64'h1000);

    // Round robin with all masters requesting; bank answers one cycle later.
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 1'b1, (c != 0), DW'(c), 4'b1111);
      check($sformatf("rr_gnt%0d", c),  64'(mas_gnt_o),     64'(rr_gnt[c]));
      check($sformatf("rr_rval%0d", c), 64'(mas_r_valid_o), 64'(rr_rval[c]));
    end
    check("rr_be_m0", 64'(slv_be_o), 64'h1);
    drive(4'b0000, 1'b1, 1'b1, '0, 4'b1111);
    check("rr_drain_rval", 64'(mas_r_valid_o), 64'b0001);

    // Pointer skip: grant master 1 alone to park rr at 2, then 1 and 3 request.
    drive(4'b0010, 1'b1, 1'b0, '0, 4'b1111);
    check("skip_pre_gnt", 64'(mas_gnt_o), 64'b0010);
    for (int c = 0; c < 3; c++) begin
      drive(4'b1010, 1'b1, 1'b1, '0, 4'b1111);
      check($sformatf("skip_gnt%0d", c),  64'(mas_gnt_o),     64'(sk_gnt[c]));
      check($sformatf("skip_rval%0d", c), 64'(mas_r_valid_o), 64'(sk_rval[c]));
    end
    drive(4'b0000, 1'b0, 1'b1, '0, 4'b1111);
    check("skip_drain_rval", 64'(mas_r_valid_o), 64'b1000);

    // Response routing: m2 reads 0x40, m0 reads 0x80.
    mas_addr_i[2] = 32'h40;
    mas_addr_i[0] = 32'h80;
    mas_wen_i     = 4'b0000;
    drive(4'b0100, 1'b1, 1'b0, '0, 4'b1111);
    check("route_gnt_m2",  64'(mas_gnt_o),  64'b0100);
    check("route_addr_m2", 64'(slv_addr_o), 64'h40);
    check("route_wen_m2",  64'(slv_wen_o),  64'd0);
    drive(4'b0001, 1'b1, 1'b0, '0, 4'b1111);
    check("route_gnt_m0",  64'(mas_gnt_o),  64'b0001);
    check("route_addr_m0", 64'(slv_addr_o), 64'h80);
    drive(4'b0000, 1'b0, 1'b1, 32'hAAAA, 4'b1111);
    check("route_out2",   64'(outstanding_o),   64'd2);
    check("route_rval_a", 64'(mas_r_valid_o),   64'b0100);
    check("route_data_a", 64'(mas_r_data_o[2]), 64'hAAAA);
    drive(4'b0000, 1'b0, 1'b1, 32'h5555, 4'b1111);
    check("route_out1",   64'(outstanding_o),   64'd1);
    check("route_rval_b", 64'(mas_r_valid_o),   64'b0001);
    check("route_data_b", 64'(mas_r_data_o[0]), 64'h5555);
    drive(4'b0000, 1'b0, 1'b0, '0, 4'b1111);
    check("route_out0",   64'(outstanding_o),   64'd0);

    // Full FIFO: rr=1 here, four grants fill it, the fifth is blocked.
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 1'b1, 1'b0, '0, 4'b1111);
      check($sformatf("full_gnt%0d", c), 64'(mas_gnt_o), 64'(fl_gnt[c]));
    end
    drive(4'b1111, 1'b1, 1'b0, '0, 4'b1111);
    check("full_out",     64'(outstanding_o), 64'd4);
    check("full_req",     64'(slv_req_o),     64'd0);
    check("full_gnt",     64'(mas_gnt_o),     64'd0);
    drive(4'b1111, 1'b1, 1'b1, '0, 4'b1111);
    check("full_pop_req",  64'(slv_req_o),     64'd0);
    check("full_pop_gnt",  64'(mas_gnt_o),     64'd0);
    check("full_pop_rval", 64'(mas_r_valid_o), 64'b0010);
    drive(4'b1111, 1'b1, 1'b0, '0, 4'b1111);
    check("full_after_out", 64'(outstanding_o), 64'd3);
    check("full_after_gnt", 64'(mas_gnt_o),     64'b0010);

    // Backpressure: FIFO holds IDs 2,3,0,1; drain three to leave master 1 at head.
    for (int c = 0; c < 3; c++) drive(4'b0000, 1'b0, 1'b1, '0, 4'b1111);
    drive(4'b0000, 1'b0, 1'b1, '0, 4'b1101);
    check("bp_out_before", 64'(outstanding_o), 64'd1);
    check("bp_ready_low",  64'(slv_r_ready_o), 64'd0);
    check("bp_rval",       64'(mas_r_valid_o), 64'b0010);
    drive(4'b0000, 1'b0, 1'b1, '0, 4'b1111);
    check("bp_held",       64'(outstanding_o), 64'd1);
    check("bp_ready_high", 64'(slv_r_ready_o), 64'd1);
    drive(4'b0000, 1'b0, 1'b0, '0, 4'b1111);
    check("bp_popped_one", 64'(outstanding_o), 64'd0);

    // Error: response with empty FIFO, flag is sticky.
    drive(4'b0000, 1'b0, 1'b1, '0, 4'b1111);
    check("err_rval",   64'(mas_r_valid_o), 64'd0);
    check("err_ready",  64'(slv_r_ready_o), 64'd0);
    check("err_before", 64'(resp_err_o),    64'd0);
    drive(4'b0000, 1'b0, 1'b0, '0, 4'b1111);
    check("err_set",    64'(resp_err_o),    64'd1);
    drive(4'b0001, 1'b1, 1'b0, '0, 4'b1111);
    check("err_gnt_m0", 64'(mas_gnt_o),     64'b0001);
    drive(4'b0000, 1'b0, 1'b0, '0, 4'b1111);
    check("err_sticky", 64'(resp_err_o),    64'd1);
    check("err_out1",   64'(outstanding_o), 64'd1);

    // Asynchronous reset mid-traffic (rr was 1 before it).
    #2;
    resetn_i = 1'b0;
    #1;
    check("mrst_err", 64'(resp_err_o),    64'd0);
    check("mrst_out", 64'(outstanding_o), 64'd0);
    @(negedge clk_i);
    resetn_i = 1'b1;
    drive(4'b0000, 1'b0, 1'b1, '0, 4'b1111);
    check("late_rval", 64'(mas_r_valid_o), 64'd0);
    drive(4'b1111, 1'b1, 1'b0, '0, 4'b1111);
    check("late_err",  64'(resp_err_o),    64'd1);
    check("mrst_rr0",  64'(mas_gnt_o),     64'b0001);

    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_arbiter.md
# tcdm_bank_arbiter

Per-bank N:1 round-robin arbiter with in-order response routing for the TCDM interconnect. It sits between the master-side request lines of the crossbar and one memory bank (slave port). It shares the bank among `NUM_MASTER` requesters and tracks granted requests in an ID FIFO so each bank response returns to the master that issued it. One instance serves each bank.

## Interface
- `NUM_MASTER`, default 4: number of requesting masters; must be ≥ 2.
- `DATA_WIDTH`, default 32: data width in bits.
- `ADDR_WIDTH`, default 32: address width in bits.
- `BE_WIDTH`, default `DATA_WIDTH/8`: byte-enable width.
- `MAX_OUTSTANDING`, default 4: depth of the response-ID FIFO; must be ≥ 1.
- `IDW`, derived: `$clog2(NUM_MASTER)`.
- `CNTW`, derived: `$clog2(MAX_OUTSTANDING+1)`.

Ports:
- `clk_i` in 1: single clock; all state on the rising edge.
- `resetn_i` in 1: asynchronous, active-low reset.
- `mas_req_i` in [NUM_MASTER]: request per master.
- `mas_gnt_o` out [NUM_MASTER]: grant per master; at most one bit set.
- `mas_addr_i` in [NUM_MASTER][ADDR_WIDTH]: address.
- `mas_wen_i` in [NUM_MASTER]: 1 = write, 0 = read.
- `mas_be_i` in [NUM_MASTER][BE_WIDTH]: byte enables.
- `mas_data_i` in [NUM_MASTER][DATA_WIDTH]: write data.
- `mas_r_data_o` out [NUM_MASTER][DATA_WIDTH]: `slv_r_data_i` broadcast to every master.
- `mas_r_valid_o` out [NUM_MASTER]: response valid, one-hot to the owning master.
- `mas_r_ready_i` in [NUM_MASTER]: master accepts response.
- `slv_req_o`, `slv_gnt_i`, `slv_addr_o`, `slv_wen_o`, `slv_be_o`, `slv_data_o`: bank request channel (out, in, out, out, out, out), same widths as the master side.
- `slv_r_data_i` in DATA_WIDTH, `slv_r_valid_i` in 1, `slv_r_ready_o` out 1: bank response channel.
- `outstanding_o` out CNTW: current FIFO occupancy.
- `resp_err_o` out 1: sticky flag; a response arrived with no outstanding request.

## Operation
- **State:**
  - round-robin pointer `rr` (IDW bits);
  - ID FIFO of `MAX_OUTSTANDING` entries of IDW bits, with read pointer, write pointer and count;
  - `resp_err_o` register.
- **Arbitration (combinational):**
  - The winner `w` is the first index `i` with `mas_req_i[i]=1`, scanning `rr, rr+1, … , NUM_MASTER-1, 0, …` with wrap.
- **Request channel:**
  - `slv_req_o = |mas_req_i & (count != MAX_OUTSTANDING)`.
  - `slv_addr_o`, `slv_wen_o`, `slv_be_o` and `slv_data_o` are muxed from `w`. When no master requests, they carry master 0's values.
  - `mas_gnt_o[w] = slv_req_o & slv_gnt_i`; all other grant bits are 0.
- **On request handshake** (`slv_req_o & slv_gnt_i`):
  - push `w` into the FIFO;
  - `rr <= (w == NUM_MASTER-1) ? 0 : w+1`.
- **Pointer hold:** with no handshake, `rr` holds, including when `slv_gnt_i=0`. The winner may change while the bank stalls, because the masters' requests may change.
- **Responses:** every granted request, read or write, produces exactly one bank response. The bank returns responses in order.
- **Response routing** (`h` = FIFO head):
  - When the FIFO is not empty: `mas_r_valid_o[h] = slv_r_valid_i` and `slv_r_ready_o = mas_r_ready_i[h]`.
  - When the FIFO is empty: `mas_r_valid_o = 0`, `slv_r_ready_o = 0`.
  - Pop on `slv_r_valid_i & slv_r_ready_o`.
- **Full FIFO:** `slv_req_o` is forced to 0 and no grant is issued. A pop in the same cycle does not unblock the request; there is no bypass.
- **Simultaneous push and pop** (FIFO not full): count is unchanged and both pointers advance modulo `MAX_OUTSTANDING`.
- **Empty FIFO with `slv_r_valid_i=1`:** the response is ignored and `resp_err_o` is set to 1 on the next edge. `resp_err_o` is cleared only by reset.
- **`outstanding_o`** equals count, in the range 0..MAX_OUTSTANDING.

## Timing
- **Reset values** (asynchronous): `rr=0`, FIFO empty, `resp_err_o=0`. During reset, all combinational outputs follow this empty state, so `slv_r_ready_o=0` and `mas_r_valid_o=0`.
- **Reset mid-operation:** all outstanding IDs are discarded. After release, a late bank response sets `resp_err_o`.
- **Zero-cycle paths:**
  - Request path: `mas_req_i` to `slv_req_o`, and `slv_gnt_i` to `mas_gnt_o`.
  - Response path: `slv_r_valid_i` to `mas_r_valid_o`, and `mas_r_ready_i` to `slv_r_ready_o`.
- **Master rule:** a master keeps `req`, `addr`, `wen`, `be` and `data` stable until it sees `gnt`.
- **Timing of state updates:** a response may be accepted in the cycle after its request handshake, at the earliest. `rr` and the FIFO update on the edge that ends the handshake cycle.
- **Throughput:** one grant per cycle with `slv_gnt_i=1` and the FIFO not full.

## Test plan
- **Round-robin order:** `NUM_MASTER=4`, all four `req` held, `slv_gnt_i=1` always → grants go to 0,1,2,3,0 on consecutive cycles.
- **Pointer skip:** only masters 1 and 3 request, with `rr=2` → first grant to 3, then 1, then 3.
- **Response routing:** master 2 reads addr `0x40`, then master 0 reads addr `0x80`; the bank returns `0xAAAA` then `0x5555` → `mas_r_valid_o` is `0b0100` then `0b0001` with matching data, and `outstanding_o` goes 2→1→0.
- **Full FIFO:** `MAX_OUTSTANDING=4`, 4 grants with no responses → the 5th request sees `slv_req_o=0` and no grant. A response pop in cycle t allows a grant in cycle t+1.
- **Response backpressure:** head is master 1 with `mas_r_ready_i[1]=0` → `slv_r_ready_o=0` and the FIFO holds. Raising ready pops exactly one entry.
- **Error and reset:** `slv_r_valid_i=1` with the FIFO empty → `resp_err_o=1` on the next edge, and it stays set. Asserting `resetn_i=0` mid-traffic clears it, empties the FIFO and sets `rr=0`.
